spinner_multi: RTL and testbench
================================

Name: spinner_multi

Overview:
- Multi-channel paddle/spinner position generator for arcade input mapping. Generalises the single-channel spinner to N independent channels.
- Each channel has a fractional accumulator driven by two sources: digital left/right steps on video-strobe edges, and MiSTer hardware spinner deltas.
- Each channel runs in wrap or clamp mode, selected at runtime.
- Sits in the emu top level between the input/spinner sources and the core's input ports (e.g. input_1 angle nibbles).

Parameters:
- CHANNELS, 2: number of independent channels.
- WIDTH, 4: output position width per channel.
- SLOW_STEP, 1: digital step size in output LSBs when fast=0.
- FAST_STEP, 2: digital step size in output LSBs when fast=1.
- SPIN_SHIFT, 2: fractional bits. Hardware delta is added at 1/2^SPIN_SHIFT of an output LSB.
- RESET_VAL, 0: output position after reset (WIDTH bits).
- ACCEL_AFTER, 8: strobe events before each acceleration stage. Used only with the optional feature.

Ports:
- clk  in  1  system clock (clk_sys).
- reset  in  1  synchronous, active-high.
- strobe  in  1  step timebase, typically VSync. Its rising edge is the step event.
- plus  in  CHANNELS  per-channel increment request.
- minus  in  CHANNELS  per-channel decrement request.
- fast  in  CHANNELS  per-channel fast step select.
- clamp_mode  in  CHANNELS  1 = saturate, 0 = wrap.
- spin_in  in  CHANNELS*9  per channel: bit 8 toggles on each update; bits 7:0 hold the signed delta. Channel c occupies bits [9c+8:9c].
- spin_out  out  CHANNELS*WIDTH  registered position; channel c occupies bits [WIDTH*c+WIDTH-1:WIDTH*c].
- changed  out  CHANNELS  one-cycle pulse when a channel's spin_out value changes.

Behaviour:
- Per-channel state:
  - acc: unsigned, WIDTH+SPIN_SHIFT bits.
  - prev_tog: last value of spin_in bit 8.
  - Shared prev_strobe register.
  - spin_out = acc[top WIDTH bits], registered.
- Reset (synchronous):
  - acc <= RESET_VAL<<SPIN_SHIFT; changed <= 0.
  - prev_strobe <= strobe; prev_tog <= spin_in bit 8. No spurious event is taken on the first cycle after reset.
  - Reset mid-operation discards any pending event.
- Step event: strobe & ~prev_strobe. Produces one event per rising edge, shared by all channels.
- Digital term d, applied on a step event only:
  - plus & ~minus → +step.
  - minus & ~plus → −step.
  - both asserted or neither asserted → 0.
  - step = (fast ? FAST_STEP : SLOW_STEP) << SPIN_SHIFT.
- Hardware term h: when spin_in bit 8 != prev_tog, h = sign-extended delta[7:0]; otherwise 0. prev_tog is updated every cycle.
- Both terms in the same cycle: sum = acc + d + h, computed signed at WIDTH+SPIN_SHIFT+2 bits. Both terms are always applied, never dropped.
- Wrap (clamp_mode=0): acc <= sum mod 2^(WIDTH+SPIN_SHIFT).
- Clamp (clamp_mode=1): acc <= sum saturated to [0, 2^(WIDTH+SPIN_SHIFT)−1].
- clamp_mode is sampled in the same cycle as the event. A mode change alone never alters acc.
- Latency: an event in cycle N appears on spin_out and changed in cycle N+1.
- changed is 1 only if the new spin_out differs from the old spin_out. It stays 0 when:
  - the position is saturated at a limit, or
  - only fractional bits move.
- Channels are fully independent apart from the shared strobe.

Optional Feature:
- Macro: SPINNER_ACCEL_EN.
- Defined:
  - Per channel, a hold counter counts step events while the same single direction stays held. It saturates at 2*ACCEL_AFTER.
  - Step multiplier: ×1 while count < ACCEL_AFTER; ×2 while count < 2*ACCEL_AFTER; ×4 after that.
  - The multiplier applies to the digital term only.
  - The counter clears on release, on both directions held, on direction reversal, and on reset.
- Undefined: no counter logic; the multiplier is always ×1 and ACCEL_AFTER is ignored.

Test Plan:
- Constant step: reset, ch0 plus=1, 3 strobe rising edges → ch0 spin_out 1,2,3, each one cycle after its edge; changed[0] pulses 3 times; ch1 stays 0.
- Wrap and clamp limits:
  - wrap: ch0 at 15, plus + edge → 0, changed=1.
  - clamp: ch0 at 15, plus + edge → stays 15, changed=0.
  - clamp: ch0 at 0, minus + edge → stays 0.
- Hardware delta, clamp_mode=0: toggle spin_in bit 8 with delta 0x06 → spin_out 1 (acc 6); toggle again with 0x06 → 3 (acc 12); toggle with 0xFF → 2 (acc 11).
- Same-cycle sources: from acc 0, strobe edge with plus=1, fast=1, and a spin toggle with delta 0x04 in the same cycle → acc 12, spin_out 3, in a single cycle.
- Null and reset cases:
  - plus=minus=1 over 4 edges → no change.
  - Assert reset while spin_in bit 8=1 and strobe=1, release with both held → no event; spin_out = RESET_VAL.
- With SPINNER_ACCEL_EN, ACCEL_AFTER=2, plus held for 6 edges → spin_out 1,2,4,6,10,14. Releasing plus, then pressing it again, restores a step of 1.

Source files
------------

// File: rtl/spinner_multi.sv
// Multi-channel spinner/paddle position generator: per-channel fractional accumulator fed by
// strobe-timed digital steps and hardware spinner deltas. Define SPINNER_ACCEL_EN for hold acceleration.
module spinner_multi #(
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SLOW_STEP   = 1,
  parameter int unsigned FAST_STEP   = 2,
  parameter int unsigned SPIN_SHIFT  = 2,
  parameter int unsigned RESET_VAL   = 0,
  parameter int unsigned ACCEL_AFTER = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      strobe,
  input  logic [CHANNELS-1:0]       plus,
  input  logic [CHANNELS-1:0]       minus,
  input  logic [CHANNELS-1:0]       fast,
  input  logic [CHANNELS-1:0]       clamp_mode,
  input  logic [CHANNELS*9-1:0]     spin_in,
  output logic [CHANNELS*WIDTH-1:0] spin_out,
  output logic [CHANNELS-1:0]       changed
);

  localparam int unsigned AW = WIDTH + SPIN_SHIFT;
  localparam int unsigned SW = AW + 2;

  localparam logic [AW-1:0]        AccReset = AW'(RESET_VAL << SPIN_SHIFT);
  localparam logic signed [SW-1:0] SlowD    = SW'(SLOW_STEP << SPIN_SHIFT);
  localparam logic signed [SW-1:0] FastD    = SW'(FAST_STEP << SPIN_SHIFT);
  localparam logic signed [SW-1:0] AccMax   = SW'((1 << AW) - 1);

  if (ACCEL_AFTER < 1) begin : g_bad_accel
    $error("ACCEL_AFTER must be at least 1");
  end

  logic strobe_q;
  logic step_ev;

  // Reset also loads the live strobe, so no edge is seen on the first cycle after reset.
  always_ff @(posedge clk) begin
    strobe_q <= strobe;
  end

  assign step_ev = strobe & ~strobe_q;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [AW-1:0]        acc_q, acc_d;
    logic                 tog_q;
    logic                 changed_q, changed_d;
    logic                 tog;
    logic signed [7:0]    delta;
    logic                 single;
    logic [1:0]           mult_shift;
    logic signed [SW-1:0] d_mag, d_term, h_term, sum;

    assign tog    = spin_in[9*c+8];
    assign delta  = spin_in[9*c +: 8];
    assign single = plus[c] ^ minus[c];

`ifdef SPINNER_ACCEL_EN
    localparam int unsigned CntW = $clog2(2 * ACCEL_AFTER + 1);
    localparam logic [CntW-1:0] Stage1 = CntW'(ACCEL_AFTER);
    localparam logic [CntW-1:0] Stage2 = CntW'(2 * ACCEL_AFTER);

    logic [CntW-1:0] cnt_q, cnt_d, cnt_eff;
    logic            dir_q;

    // Release, both held or reversal all drop the effective count to zero.
    always_comb begin
      cnt_eff    = (single && (plus[c] == dir_q)) ? cnt_q : '0;
      mult_shift = 2'd0;
      if (cnt_eff >= Stage2) begin
        mult_shift = 2'd2;
      end else if (cnt_eff >= Stage1) begin
        mult_shift = 2'd1;
      end
      cnt_d = cnt_eff;
      if (step_ev && single && (cnt_eff < Stage2)) begin
        cnt_d = cnt_eff + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q <= '0;
        dir_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        if (single) dir_q <= plus[c];
      end
    end
`else
    assign mult_shift = 2'd0;
`endif

    always_comb begin
      d_mag  = (fast[c] ? FastD : SlowD) << mult_shift;
      d_term = '0;
      if (step_ev && single) begin
        d_term = plus[c] ? d_mag : -d_mag;
      end
      h_term = (tog != tog_q) ? SW'(delta) : '0;
      sum    = $signed({2'b00, acc_q}) + d_term + h_term;
      acc_d  = sum[AW-1:0];
      if (clamp_mode[c]) begin
        if (sum < 0) begin
          acc_d = '0;
        end else if (sum > AccMax) begin
          acc_d = '1;
        end
      end
      changed_d = acc_d[AW-1 -: WIDTH] != acc_q[AW-1 -: WIDTH];
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        acc_q     <= AccReset;
        changed_q <= 1'b0;
        tog_q     <= tog;
      end else begin
        acc_q     <= acc_d;
        changed_q <= changed_d;
        tog_q     <= tog;
      end
    end

    assign spin_out[WIDTH*c +: WIDTH] = acc_q[AW-1 -: WIDTH];
    assign changed[c]                 = changed_q;
  end

endmodule

// File: tb/tb_spinner_multi.sv
// Self-checking bench for spinner_multi: directed literal cases plus randomized stimulus
// compared every cycle against an integer reference model.
module tb_spinner_multi;

  localparam int CH = 2;
  localparam int W  = 4;
  localparam int SH = 2;
  localparam int AMOD = 1 << (W + SH);

  logic            clk;
  logic            reset;
  logic            strobe;
  logic [CH-1:0]   plus, minus, fast, clamp_mode;
  logic [CH*9-1:0] spin_in;
  logic [CH*W-1:0] spin_out;
  logic [CH-1:0]   changed;

  int n_cmp  = 0;
  int n_fail = 0;
  bit check_en = 0;

  // Reference model state
  int   m_acc [CH];
  bit   m_chg [CH];
  logic m_pstrobe;
  logic m_ptog [CH];

  spinner_multi dut (
    .clk        (clk),
    .reset      (reset),
    .strobe     (strobe),
    .plus       (plus),
    .minus      (minus),
    .fast       (fast),
    .clamp_mode (clamp_mode),
    .spin_in    (spin_in),
    .spin_out   (spin_out),
    .changed    (changed)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: position = acc / 2^SH; everything in plain integers.
  always @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < CH; c++) begin
        m_acc[c]  = 0;
        m_chg[c]  = 0;
        m_ptog[c] = spin_in[9*c+8];
      end
      m_pstrobe = strobe;
    end else begin
      bit ev;
      ev = strobe && !m_pstrobe;
      for (int c = 0; c < CH; c++) begin
        int d, h, s, nxt;
        d = 0;
        h = 0;
        if (ev && (plus[c] != minus[c])) begin
          d = (fast[c] ? 2 : 1) * 4;
          if (minus[c]) d = -d;
        end
        if (spin_in[9*c+8] != m_ptog[c]) h = int'($signed(spin_in[9*c +: 8]));
        s = m_acc[c] + d + h;
        if (clamp_mode[c]) nxt = (s < 0) ? 0 : (s > AMOD - 1) ? AMOD - 1 : s;
        else nxt = ((s % AMOD) + AMOD) % AMOD;
        m_chg[c]  = (nxt / 4) != (m_acc[c] / 4);
        m_acc[c]  = nxt;
        m_ptog[c] = spin_in[9*c+8];
      end
      m_pstrobe = strobe;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      for (int c = 0; c < CH; c++) begin
        check("model_pos", 32'(spin_out[W*c +: W]), 32'(m_acc[c] / 4));
        check("model_chg", 32'(changed[c]), 32'(m_chg[c]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    tick();
    tick();
    @(negedge clk);
    reset = 0;
  endtask

  // Strobe rising edge sampled at the next posedge; caller checks afterwards.
  task automatic edge_up();
    @(negedge clk);
    strobe = 1;
    tick();
  endtask

  task automatic edge_down();
    @(negedge clk);
    strobe = 0;
    tick();
  endtask

  task automatic toggle0(input logic [7:0] dl);
    @(negedge clk);
    spin_in[8]   = ~spin_in[8];
    spin_in[7:0] = dl;
    tick();
  endtask

  initial begin
    reset = 1; strobe = 0; plus = 0; minus = 0; fast = 0; clamp_mode = 0; spin_in = '0;
    tick();
    check_en = 1;
    do_reset();
    tick();
    check("reset_pos0", 32'(spin_out[3:0]), 32'd0);
    check("reset_chg", 32'(changed), 32'd0);

    // Constant step
    plus[0] = 1;
    for (int k = 1; k <= 3; k++) begin
      edge_up();
      check("step_pos0", 32'(spin_out[3:0]), 32'(k));
      check("step_chg0", 32'(changed[0]), 32'd1);
      check("step_pos1", 32'(spin_out[7:4]), 32'd0);
      edge_down();
      check("step_chg0_clr", 32'(changed[0]), 32'd0);
    end

    // Wrap at top
    toggle0(8'd48);
    check("hw_to_15", 32'(spin_out[3:0]), 32'd15);
    edge_up();
    check("wrap_pos", 32'(spin_out[3:0]), 32'd0);
    check("wrap_chg", 32'(changed[0]), 32'd1);
    edge_down();

    // Clamp at top and bottom
    clamp_mode[0] = 1;
    toggle0(8'd60);
    check("hw_to_15b", 32'(spin_out[3:0]), 32'd15);
    edge_up();
    check("clamp_hi_pos", 32'(spin_out[3:0]), 32'd15);
    check("clamp_hi_chg", 32'(changed[0]), 32'd0);
    edge_down();
    plus[0] = 0; minus[0] = 1;
    toggle0(8'hC1);
    check("hw_to_0", 32'(spin_out[3:0]), 32'd0);
    edge_up();
    check("clamp_lo_pos", 32'(spin_out[3:0]), 32'd0);
    check("clamp_lo_chg", 32'(changed[0]), 32'd0);
    edge_down();

    // Hardware deltas in wrap mode
    minus[0] = 0; clamp_mode[0] = 0;
    do_reset();
    toggle0(8'h06);
    check("hw_a", 32'(spin_out[3:0]), 32'd1);
    toggle0(8'h06);
    check("hw_b", 32'(spin_out[3:0]), 32'd3);
    toggle0(8'hFF);
    check("hw_c", 32'(spin_out[3:0]), 32'd2);

    // Both sources in one cycle
    do_reset();
    plus[0] = 1; fast[0] = 1;
    @(negedge clk);
    strobe = 1;
    spin_in[8] = ~spin_in[8];
    spin_in[7:0] = 8'h04;
    tick();
    check("same_cycle", 32'(spin_out[3:0]), 32'd3);
    edge_down();

    // Both directions held: no movement
    minus[0] = 1;
    for (int k = 0; k < 4; k++) begin
      edge_up();
      check("null_pos", 32'(spin_out[3:0]), 32'd3);
      check("null_chg", 32'(changed[0]), 32'd0);
      edge_down();
    end

    // Reset with toggle and strobe high, released while held
    @(negedge clk);
    reset = 1; strobe = 1; spin_in[8] = 1; spin_in[7:0] = 8'h05; minus[0] = 0; fast[0] = 0;
    tick();
    tick();
    @(negedge clk);
    reset = 0;
    tick();
    check("rst_hold_pos", 32'(spin_out), 32'd0);
    check("rst_hold_chg", 32'(changed), 32'd0);
    tick();
    check("rst_hold_pos2", 32'(spin_out), 32'd0);
    edge_down();

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      reset      = ($urandom_range(0, 199) == 0);
      strobe     = 1'($urandom_range(0, 1));
      plus       = CH'($urandom);
      minus      = CH'($urandom);
      fast       = CH'($urandom);
      if ($urandom_range(0, 15) == 0) clamp_mode = CH'($urandom);
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 3) == 0) begin
          spin_in[9*c+8]   = ~spin_in[9*c+8];
          spin_in[9*c +: 8] = 8'($urandom_range(0, 40) - 20);
        end
      end
    end
    @(negedge clk);
    check_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
